// File: rtl/ofdm_fft_pkg.sv
// Shared constants, complex sample type and butterfly arithmetic helper
// for the 16-point OFDM FFT datapath.
package ofdm_fft_pkg;

  localparam int unsigned DATA_W   = 24;
  localparam int unsigned FRAC_W   = 8;
  localparam int unsigned N        = 16;
  localparam int unsigned HALF_N   = N / 2;
  localparam int unsigned PHASE_W  = $clog2(N);
  localparam int unsigned TW_IDX_W = $clog2(HALF_N);

  // Unity in the Q(DATA_W-FRAC_W).FRAC_W sample/twiddle format.
  localparam logic signed [DATA_W-1:0] ONE = DATA_W'(24'h000100);

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  // (a +/- b) >>> 1 evaluated one bit wider so the sum never overflows.
  function automatic logic signed [DATA_W-1:0] half_addsub(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic                     sub
  );
    logic signed [DATA_W:0] s;
    s = sub ? ((DATA_W+1)'(a) - (DATA_W+1)'(b))
            : ((DATA_W+1)'(a) + (DATA_W+1)'(b));
    return DATA_W'(s >>> 1);
  endfunction

endpackage

// File: rtl/sdf_bf_stage16_cplx_mult.sv
// Combinational complex multiply with FRAC_W rescale; result wraps to DATA_W.
module cplx_mult
  import ofdm_fft_pkg::*;
(
  input  cplx_t a_i,
  input  cplx_t b_i,
  output cplx_t prod_o_c
);

  localparam int unsigned PROD_W = 2 * DATA_W + 1;

  logic signed [PROD_W-1:0] rr, ii, ri, ir;
  logic signed [PROD_W-1:0] re_full, im_full;

  assign rr = PROD_W'(a_i.re) * PROD_W'(b_i.re);
  assign ii = PROD_W'(a_i.im) * PROD_W'(b_i.im);
  assign ri = PROD_W'(a_i.re) * PROD_W'(b_i.im);
  assign ir = PROD_W'(a_i.im) * PROD_W'(b_i.re);

  assign re_full = rr - ii;
  assign im_full = ri + ir;

  assign prod_o_c.re = DATA_W'(re_full >>> FRAC_W);
  assign prod_o_c.im = DATA_W'(im_full >>> FRAC_W);

endmodule

// File: rtl/sdf_bf_stage16.sv
// Radix-2 DIF single-delay-feedback butterfly stage for the 16-point FFT:
// 8 butterfly sums per frame followed by 8 twiddled differences.
module sdf_bf_stage16
  import ofdm_fft_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [DATA_W-1:0]   din_r,
  input  logic signed [DATA_W-1:0]   din_i,
  output logic [TW_IDX_W-1:0]        tw_idx,
  input  logic signed [DATA_W-1:0]   tw_r,
  input  logic signed [DATA_W-1:0]   tw_i,
  output logic                       out_valid,
  output logic signed [DATA_W-1:0]   dout_r,
  output logic signed [DATA_W-1:0]   dout_i,
  output logic                       frame_start
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               filled_q, filled_d;
  cplx_t              dly_q [HALF_N];
  cplx_t              dly_d [HALF_N];
  logic               out_valid_q, out_valid_d;
  logic               frame_start_q, frame_start_d;
  cplx_t              dout_q, dout_d;

  cplx_t head_c, din_c, tw_c, prod_c, sum_c, diff_c;
  logic  bf_phase_c;

  // Head of the delay line is the entry written HALF_N accepted samples ago.
  assign head_c     = dly_q[HALF_N-1];
  assign din_c      = '{re: din_r, im: din_i};
  assign tw_c       = '{re: tw_r, im: tw_i};
  assign bf_phase_c = phase_q[PHASE_W-1];
  assign tw_idx     = phase_q[TW_IDX_W-1:0];

  assign sum_c.re  = half_addsub(head_c.re, din_c.re, 1'b0);
  assign sum_c.im  = half_addsub(head_c.im, din_c.im, 1'b0);
  assign diff_c.re = half_addsub(head_c.re, din_c.re, 1'b1);
  assign diff_c.im = half_addsub(head_c.im, din_c.im, 1'b1);

  cplx_mult u_cplx_mult (
    .a_i      (head_c),
    .b_i      (tw_c),
    .prod_o_c (prod_c)
  );

  always_comb begin
    phase_d       = phase_q;
    filled_d      = filled_q;
    dly_d         = dly_q;
    out_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    dout_d        = dout_q;
    if (in_valid) begin
      phase_d = phase_q + PHASE_W'(1);
      if (phase_q == PHASE_W'(HALF_N - 1)) filled_d = 1'b1;
      for (int unsigned i = 1; i < HALF_N; i++) dly_d[i] = dly_q[i-1];
      out_valid_d   = filled_q | bf_phase_c;
      frame_start_d = (phase_q == PHASE_W'(HALF_N));
      if (bf_phase_c) begin
        dly_d[0] = diff_c;
        dout_d   = sum_c;
      end else begin
        dly_d[0] = din_c;
        // Fill-only samples of the first frame leave dout untouched.
        if (filled_q) dout_d = prod_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q       <= '0;
      filled_q      <= 1'b0;
      for (int unsigned i = 0; i < HALF_N; i++) dly_q[i] <= '0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      dout_q        <= '0;
    end else begin
      phase_q       <= phase_d;
      filled_q      <= filled_d;
      dly_q         <= dly_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
      dout_q        <= dout_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign frame_start = frame_start_q;
  assign dout_r      = dout_q.re;
  assign dout_i      = dout_q.im;

endmodule
